snake_logic: RTL

- Game-board datapath that answers the snake controller's tick/done handshake.
- On each accepted tick it advances the snake one cell in the commanded direction, detects wall and body collisions, grows on food, and places new food through a request/acknowledge exchange with the PRNG datapath.
- It drives the 8x8 LED bitmap that the controller multiplexes onto the display, and it blinks the head LED after game over.

---
 rtl/snake_logic.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/snake_logic.sv
// -----------------------------------------------------------------------------
// snake_logic
//   Game-board datapath for the snake game. It answers the controller's
//   tick/done handshake. On each accepted tick it moves the head one cell,
//   detects wall and body collisions, grows on food, and places new food
//   through a request/acknowledge exchange with the PRNG. It also produces
//   the 8x8 LED bitmap, with the head LED blinking after game over.
//
// Ports
//   clka            in   system clock, all state updates on posedge
//   restart         in   asynchronous active-high reset
//   to_logic[1:0]   in   bit0 LOGIC_TICK, bit1 NO_UPDATE
//   direction_state in   UP=0 DOWN=1 LEFT=2 RIGHT=3, latched on tick accept
//   from_logic[1:0] out  bit0 LOGIC_DONE, bit1 GAME_END (sticky)
//   led_array       out  led_array[row][col], row 0 / col 0 is bottom-left
//   rng_req         out  new-food random value request
//   rng_ack         in   one-cycle strobe, rng_value valid
//   rng_value[5:0]  in   candidate food position {row,col}
//   length[5:0]     out  current snake length
// -----------------------------------------------------------------------------
module snake_logic #(
    parameter int         MAX_LEN   = 16,
    parameter logic [5:0] INIT_HEAD = 6'o32,
    parameter logic [5:0] INIT_FOOD = 6'o35
) (
    input  logic            clka,
    input  logic            restart,
    input  logic [1:0]      to_logic,
    input  logic [1:0]      direction_state,
    output logic [1:0]      from_logic,
    output logic [7:0][7:0] led_array,
    output logic            rng_req,
    input  logic            rng_ack,
    input  logic [5:0]      rng_value,
    output logic [5:0]      length
);

    localparam int               PTR_W     = $clog2(MAX_LEN);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(MAX_LEN - 1);
    localparam logic [5:0]       MAX_LEN_L = 6'(MAX_LEN);
    localparam logic [5:0]       INIT_TAIL = INIT_HEAD - 6'd1;
    localparam logic [63:0]      OCC_INIT  = (64'd1 << INIT_HEAD) | (64'd1 << INIT_TAIL);

    typedef enum logic [2:0] {S_IDLE, S_STEP, S_COMMIT, S_FOOD, S_DONE} state_t;
    typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

    state_t           r_state;
    dir_t             r_dir;
    logic [5:0]       r_body [MAX_LEN];
    logic [PTR_W-1:0] r_head_ptr;
    logic [PTR_W-1:0] r_tail_ptr;
    logic [63:0]      r_occ;
    logic [5:0]       r_food;
    logic [5:0]       r_nh;
    logic [5:0]       r_length;
    logic             r_grow;
    logic             r_blink;
    logic             r_game_end;
    logic             r_logic_done;
    logic             r_tick_q;
    logic             r_rng_req;

    logic [5:0]       w_head;
    logic [5:0]       w_tail;
    logic [5:0]       w_nh;
    logic             w_wall;
    logic             w_grow;
    logic             w_collide;
    logic             w_pop;
    logic [PTR_W-1:0] w_head_ptr_nxt;
    logic [PTR_W-1:0] w_tail_ptr_nxt;
    logic [63:0]      w_occ_commit;
    logic [63:0]      w_led;

    assign w_head = r_body[r_head_ptr];
    assign w_tail = r_body[r_tail_ptr];

    // Explicit wrap so MAX_LEN need not be a power of two.
    assign w_head_ptr_nxt = (r_head_ptr == LAST_PTR) ? '0 : r_head_ptr + PTR_W'(1);
    assign w_tail_ptr_nxt = (r_tail_ptr == LAST_PTR) ? '0 : r_tail_ptr + PTR_W'(1);

    // NOTE: combinational blocks assign every output a default first, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_nh   = w_head;
        w_wall = 1'b0;
        case (r_dir)
            DIR_UP:    begin w_wall = (w_head[5:3] == 3'd7); w_nh[5:3] = w_head[5:3] + 3'd1; end
            DIR_DOWN:  begin w_wall = (w_head[5:3] == 3'd0); w_nh[5:3] = w_head[5:3] - 3'd1; end
            DIR_LEFT:  begin w_wall = (w_head[2:0] == 3'd0); w_nh[2:0] = w_head[2:0] - 3'd1; end
            DIR_RIGHT: begin w_wall = (w_head[2:0] == 3'd7); w_nh[2:0] = w_head[2:0] + 3'd1; end
        endcase
    end

    // Moving onto the tail cell is legal when the tail vacates it this move;
    // it does not vacate when the snake grows.
    assign w_grow    = (w_nh == r_food);
    assign w_collide = w_wall | (r_occ[w_nh] & ((w_nh != w_tail) | w_grow));

    // Tail is popped on a plain move, and also on a grow at full length.
    assign w_pop        = !r_grow || (r_length == MAX_LEN_L);
    assign w_occ_commit = (r_occ & ~(w_pop ? (64'd1 << w_tail) : 64'd0)) | (64'd1 << r_nh);

    always_comb begin
        w_led         = r_occ;
        w_led[r_food] = 1'b1;
        if (r_blink) begin
            w_led[w_head] = 1'b0;
        end
    end

    assign led_array  = w_led;
    assign from_logic = {r_game_end, r_logic_done};
    assign rng_req    = r_rng_req;
    assign length     = r_length;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clka or posedge restart) begin
        if (restart) begin
            // NOTE: the body ring is reset as a whole because restart must
            // return the snake to a known two-cell body immediately.
            for (int i = 0; i < MAX_LEN; i++) begin
                r_body[i] <= '0;
            end
            r_body[0]    <= INIT_TAIL;
            r_body[1]    <= INIT_HEAD;
            r_tail_ptr   <= '0;
            r_head_ptr   <= PTR_W'(1);
            r_occ        <= OCC_INIT;
            r_food       <= INIT_FOOD;
            r_length     <= 6'd2;
            r_nh         <= '0;
            r_grow       <= 1'b0;
            r_dir        <= DIR_UP;
            r_blink      <= 1'b0;
            r_game_end   <= 1'b0;
            r_logic_done <= 1'b0;
            r_tick_q     <= 1'b0;
            r_rng_req    <= 1'b0;
            r_state      <= S_IDLE;
        end else begin
            // Tracks the tick level even while busy, so a long pulse is
            // never accepted twice.
            r_tick_q <= to_logic[0];
            case (r_state)
                S_IDLE: begin
                    if (to_logic[0] && !r_tick_q) begin
                        r_logic_done <= 1'b0;
                        r_dir        <= dir_t'(direction_state);
                        if (to_logic[1]) begin
                            r_blink <= ~r_blink;
                            r_state <= S_DONE;
                        end else if (r_game_end) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_STEP;
                        end
                    end
                end
                S_STEP: begin
                    r_nh   <= w_nh;
                    r_grow <= w_grow;
                    if (w_collide) begin
                        r_game_end <= 1'b1;
                        r_state    <= S_DONE;
                    end else begin
                        r_state <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    r_body[w_head_ptr_nxt] <= r_nh;
                    r_head_ptr             <= w_head_ptr_nxt;
                    r_occ                  <= w_occ_commit;
                    if (w_pop) begin
                        r_tail_ptr <= w_tail_ptr_nxt;
                    end
                    if (r_grow && (r_length != MAX_LEN_L)) begin
                        r_length <= r_length + 6'd1;
                    end
                    r_rng_req <= r_grow;
                    r_state   <= r_grow ? S_FOOD : S_DONE;
                end
                S_FOOD: begin
                    // Occupied candidates are discarded; the request stays up
                    // for the next strobe.
                    if (rng_ack && !r_occ[rng_value]) begin
                        r_food    <= rng_value;
                        r_rng_req <= 1'b0;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_logic_done <= 1'b1;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
